// File: rtl/fpu_seq_ctrl.sv
// Binary32 FPU sequencer: unpacks/aligns operands, drives the large-ALU en/fin handshake,
// then normalises, truncates and packs the result. Optional macro FPU_EXC_EN adds inf/NaN decode and flags.
module fpu_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] fa,
  input  logic [31:0] fb,
  output logic [31:0] fres,
  output logic        busy,
  output logic        done,
  output logic        alu_en,
  output logic [1:0]  alu_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic        alu_fin
`ifdef FPU_EXC_EN
  ,
  output logic [3:0]  flags
`endif
);

  typedef enum logic [2:0] {IDLE, PREP, ISSUE, WAITLO, WAITHI, NORM} state_t;

  state_t             state_r, state_next_s;
  logic [1:0]         op_r;
  logic [31:0]        fa_r, fb_r, res_r, spec_res_r;
  logic               sign_r, special_r;
  logic signed [9:0]  exp_r;

  logic [7:0]         ea_s, eb_s, el_s, es_s, dist_s;
  logic               za_s, zb_s, sbe_s, abig_s, sl_s;
  logic [23:0]        ma_s, mb_s, ml_s, ms_s;
  logic [31:0]        shs_s;

  logic               p_special_s, p_sign_s;
  logic [31:0]        p_spec_res_s, p_a_s, p_b_s;
  logic [1:0]         p_ctrl_s;
  logic signed [9:0]  p_exp_s;

  logic [4:0]         lz_s;
  logic               hit_s;
  logic [25:0]        shifted_s;
  logic signed [9:0]  n_exp_s;
  logic [22:0]        n_frac_s;
  logic               n_zero_s, n_of_s, n_uf_s;
  logic [31:0]        norm_res_s;
  logic               unused_s;

`ifdef FPU_EXC_EN
  logic [3:0]         p_flags_s, spec_flags_r;
  logic               na_s, nb_s, ia_s, ib_s;
`endif

  // Operand unpack and add/sub alignment of the smaller operand.
  always_comb begin
    ea_s   = fa_r[30:23];
    eb_s   = fb_r[30:23];
    za_s   = (ea_s == 8'd0);
    zb_s   = (eb_s == 8'd0);
    ma_s   = {1'b1, fa_r[22:0]};
    mb_s   = {1'b1, fb_r[22:0]};
    sbe_s  = fb_r[31] ^ op_r[0];
    abig_s = (fa_r[30:0] >= fb_r[30:0]);
    el_s   = abig_s ? ea_s : eb_s;
    es_s   = abig_s ? eb_s : ea_s;
    ml_s   = abig_s ? ma_s : mb_s;
    ms_s   = abig_s ? mb_s : ma_s;
    sl_s   = abig_s ? fa_r[31] : sbe_s;
    dist_s = el_s - es_s;
    if (dist_s >= 8'd26) begin
      shs_s = 32'd0;
    end else begin
      shs_s = {6'd0, ms_s, 2'b00} >> dist_s;
    end
  end

  // PREP decision: ALU operands, provisional sign/exponent, and special-case results.
  always_comb begin
    p_special_s  = 1'b0;
    p_spec_res_s = 32'd0;
    p_a_s        = {8'd0, ma_s};
    p_b_s        = {8'd0, mb_s};
    p_ctrl_s     = op_r;
    p_sign_s     = fa_r[31] ^ fb_r[31];
    p_exp_s      = 10'sd0;
    case (op_r)
      2'b00, 2'b01: begin
        p_sign_s = sl_s;
        p_exp_s  = $signed({2'b00, el_s});
        p_a_s    = {6'd0, ml_s, 2'b00};
        p_b_s    = shs_s;
        p_ctrl_s = (fa_r[31] == sbe_s) ? 2'b00 : 2'b01;
        if (zb_s) begin
          p_special_s  = 1'b1;
          p_spec_res_s = {fa_r[31], (za_s ? 31'd0 : fa_r[30:0])};
        end else if (za_s) begin
          p_special_s  = 1'b1;
          p_spec_res_s = {sbe_s, fb_r[30:0]};
        end else begin
          p_special_s  = 1'b0;
        end
      end
      2'b10: begin
        p_exp_s = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - 10'sd127;
        if (za_s || zb_s) begin
          p_special_s  = 1'b1;
          p_spec_res_s = {p_sign_s, 31'd0};
        end else begin
          p_special_s  = 1'b0;
        end
      end
      2'b11: begin
        p_exp_s = $signed({2'b00, ea_s}) - $signed({2'b00, eb_s}) + 10'sd127;
        if (zb_s) begin
          p_special_s  = 1'b1;
          p_spec_res_s = {p_sign_s, 31'h7F80_0000};
        end else if (za_s) begin
          p_special_s  = 1'b1;
          p_spec_res_s = {p_sign_s, 31'd0};
        end else begin
          p_special_s  = 1'b0;
        end
      end
      default: begin
        p_special_s = 1'b0;
      end
    endcase
`ifdef FPU_EXC_EN
    na_s      = (ea_s == 8'hFF) && (fa_r[22:0] != 23'd0);
    nb_s      = (eb_s == 8'hFF) && (fb_r[22:0] != 23'd0);
    ia_s      = (ea_s == 8'hFF) && (fa_r[22:0] == 23'd0);
    ib_s      = (eb_s == 8'hFF) && (fb_r[22:0] == 23'd0);
    p_flags_s = 4'd0;
    if (na_s || nb_s) begin
      p_special_s  = 1'b1;
      p_spec_res_s = 32'h7FC0_0000;
      p_flags_s    = 4'b1000;
    end else begin
      case (op_r)
        2'b00, 2'b01: begin
          if (ia_s && ib_s && (fa_r[31] != sbe_s)) begin
            p_special_s  = 1'b1;
            p_spec_res_s = 32'h7FC0_0000;
            p_flags_s    = 4'b1000;
          end else if (ia_s) begin
            p_special_s  = 1'b1;
            p_spec_res_s = {fa_r[31], 31'h7F80_0000};
          end else if (ib_s) begin
            p_special_s  = 1'b1;
            p_spec_res_s = {sbe_s, 31'h7F80_0000};
          end else begin
            p_flags_s    = 4'd0;
          end
        end
        2'b10: begin
          if ((ia_s || ib_s) && (za_s || zb_s)) begin
            p_special_s  = 1'b1;
            p_spec_res_s = 32'h7FC0_0000;
            p_flags_s    = 4'b1000;
          end else if (ia_s || ib_s) begin
            p_special_s  = 1'b1;
            p_spec_res_s = {p_sign_s, 31'h7F80_0000};
          end else begin
            p_flags_s    = 4'd0;
          end
        end
        2'b11: begin
          if ((za_s && zb_s) || (ia_s && ib_s)) begin
            p_special_s  = 1'b1;
            p_spec_res_s = 32'h7FC0_0000;
            p_flags_s    = 4'b1000;
          end else if (ia_s) begin
            p_special_s  = 1'b1;
            p_spec_res_s = {p_sign_s, 31'h7F80_0000};
          end else if (ib_s) begin
            p_special_s  = 1'b1;
            p_spec_res_s = {p_sign_s, 31'd0};
          end else if (zb_s) begin
            p_flags_s    = 4'b0100;
          end else begin
            p_flags_s    = 4'd0;
          end
        end
        default: begin
          p_flags_s = 4'd0;
        end
      endcase
    end
`endif
  end

  // Leading-one search over the add/sub result (bit 25 is the hidden-bit position).
  always_comb begin
    lz_s  = 5'd0;
    hit_s = 1'b0;
    for (int i = 25; i >= 0; i--) begin
      if (!hit_s && res_r[i]) begin
        hit_s = 1'b1;
        lz_s  = 5'(25 - i);
      end else begin
        hit_s = hit_s;
      end
    end
    shifted_s = res_r[25:0] << lz_s;
    unused_s  = ^{shifted_s[25], shifted_s[1:0]};
  end

  // NORM: renormalise the ALU result, truncate, and saturate to inf or signed zero.
  always_comb begin
    n_exp_s  = exp_r;
    n_frac_s = 23'd0;
    n_zero_s = 1'b0;
    case (op_r)
      2'b00, 2'b01: begin
        if (res_r[26]) begin
          n_exp_s  = exp_r + 10'sd1;
          n_frac_s = res_r[25:3];
        end else if (res_r == 32'd0) begin
          n_zero_s = 1'b1;
        end else begin
          n_exp_s  = exp_r - $signed({5'd0, lz_s});
          n_frac_s = shifted_s[24:2];
        end
      end
      2'b10: begin
        if (res_r[25]) begin
          n_exp_s  = exp_r + 10'sd1;
          n_frac_s = res_r[24:2];
        end else begin
          n_frac_s = res_r[23:1];
        end
      end
      2'b11: begin
        if (res_r[24]) begin
          n_frac_s = res_r[23:1];
        end else begin
          n_exp_s  = exp_r - 10'sd1;
          n_frac_s = res_r[22:0];
        end
      end
      default: begin
        n_frac_s = 23'd0;
      end
    endcase
    n_of_s = 1'b0;
    n_uf_s = 1'b0;
    if (special_r) begin
      norm_res_s = spec_res_r;
    end else if (n_zero_s) begin
      norm_res_s = 32'd0;
    end else if (n_exp_s >= 10'sd255) begin
      norm_res_s = {sign_r, 31'h7F80_0000};
      n_of_s     = 1'b1;
    end else if (n_exp_s <= 10'sd0) begin
      norm_res_s = {sign_r, 31'd0};
      n_uf_s     = 1'b1;
    end else begin
      norm_res_s = {sign_r, n_exp_s[7:0], n_frac_s};
    end
  end

  // Next-state logic for the handshake sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = start ? PREP : IDLE;
      PREP:    state_next_s = p_special_s ? NORM : ISSUE;
      ISSUE:   state_next_s = WAITLO;
      WAITLO:  state_next_s = alu_fin ? WAITLO : WAITHI;
      WAITHI:  state_next_s = alu_fin ? NORM : WAITHI;
      NORM:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r       <= 2'd0;
      fa_r       <= 32'd0;
      fb_r       <= 32'd0;
      res_r      <= 32'd0;
      spec_res_r <= 32'd0;
      sign_r     <= 1'b0;
      special_r  <= 1'b0;
      exp_r      <= 10'sd0;
      fres       <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      alu_en     <= 1'b0;
      alu_ctrl   <= 2'd0;
      alu_a      <= 32'd0;
      alu_b      <= 32'd0;
`ifdef FPU_EXC_EN
      spec_flags_r <= 4'd0;
      flags        <= 4'd0;
`endif
    end else begin
      done   <= 1'b0;
      alu_en <= 1'b0;
      busy   <= (state_next_s != IDLE);
      case (state_r)
        IDLE: begin
          if (start) begin
            fa_r <= fa;
            fb_r <= fb;
            op_r <= op;
          end
        end
        PREP: begin
          sign_r     <= p_sign_s;
          exp_r      <= p_exp_s;
          special_r  <= p_special_s;
          spec_res_r <= p_spec_res_s;
`ifdef FPU_EXC_EN
          spec_flags_r <= p_flags_s;
`endif
          if (!p_special_s) begin
            alu_a    <= p_a_s;
            alu_b    <= p_b_s;
            alu_ctrl <= p_ctrl_s;
            alu_en   <= 1'b1;
          end
        end
        WAITHI: begin
          if (alu_fin) begin
            res_r <= alu_result;
          end
        end
        NORM: begin
          fres <= norm_res_s;
          done <= 1'b1;
`ifdef FPU_EXC_EN
          flags <= special_r ? spec_flags_r : {2'b00, n_of_s, n_uf_s};
`endif
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Self-checking bench for fpu_seq_ctrl: behavioural float model, variable-latency ALU model, randomized ops.
module tb_fpu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] fa = 32'd0, fb = 32'd0;
  logic [31:0] fres, alu_a, alu_b, alu_result;
  logic        busy, done, alu_en, alu_fin;
  logic [1:0]  alu_ctrl;

  always #5 clk = ~clk;

  fpu_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .fa(fa), .fb(fb),
    .fres(fres), .busy(busy), .done(done), .alu_en(alu_en), .alu_ctrl(alu_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_fin(alu_fin)
  );

  typedef struct {
    logic [31:0] res;
    bit          special;
    logic [1:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Large-ALU model: fin drops after en, rises alu_lat cycles later with the result.
  int          alu_lat = 1;
  int          alu_cnt;

  function automatic logic [31:0] alu_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] t;
    case (c)
      2'd0: t = 64'(a) + 64'(b);
      2'd1: t = 64'(a) - 64'(b);
      2'd2: t = (64'(a) * 64'(b)) >> 22;
      default: t = (b == 32'd0) ? 64'd0 : ((64'(a) << 24) / 64'(b));
    endcase
    return t[31:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_fin    <= 1'b1;
      alu_result <= 32'd0;
      alu_cnt    <= 0;
    end else if (alu_en) begin
      alu_fin    <= 1'b0;
      alu_cnt    <= alu_lat;
      alu_result <= $urandom;
    end else if (!alu_fin) begin
      if (alu_cnt <= 1) begin
        alu_fin    <= 1'b1;
        alu_result <= alu_op(alu_ctrl, alu_a, alu_b);
      end else begin
        alu_cnt <= alu_cnt - 1;
      end
    end
  end

  // Reference: float result and expected ALU issue from the arithmetic rules.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t m;
    int ea, eb, el, es, e, d;
    bit sa, sb, sbe, s, abig;
    longint ma, mb, ml, ms, r;
    logic [22:0] frac;
    ea = int'(x[30:23]);
    eb = int'(y[30:23]);
    sa = x[31];
    sb = y[31];
    ma = 64'h80_0000 + longint'(x[22:0]);
    mb = 64'h80_0000 + longint'(y[22:0]);
    m.res = 32'd0; m.special = 1'b0; m.ctrl = o; m.a = 32'd0; m.b = 32'd0;
    s = sa ^ sb;
    e = 0;
    frac = 23'd0;
    if (o[1] == 1'b0) begin
      sbe = sb ^ o[0];
      if (eb == 0) begin
        m.special = 1'b1;
        m.res = (ea == 0) ? {sa, 31'd0} : x;
        return m;
      end
      if (ea == 0) begin
        m.special = 1'b1;
        m.res = {sbe, y[30:0]};
        return m;
      end
      abig = (x[30:0] >= y[30:0]);
      el = abig ? ea : eb;
      es = abig ? eb : ea;
      s  = abig ? sa : sbe;
      ml = (abig ? ma : mb) * 4;
      ms = (abig ? mb : ma) * 4;
      d  = el - es;
      ms = (d >= 26) ? 64'd0 : (ms >> d);
      m.ctrl = (sa == sbe) ? 2'd0 : 2'd1;
      m.a = ml[31:0];
      m.b = ms[31:0];
      r = (m.ctrl == 2'd0) ? ml + ms : ml - ms;
      if (r == 0) begin
        m.res = 32'd0;
        return m;
      end
      e = el;
      if (r >= (64'd1 << 26)) begin r = r >> 1; e++; end
      while (r < (64'd1 << 25)) begin r = r << 1; e--; end
      frac = 23'(r >> 2);
    end else if (o == 2'd2) begin
      if (ea == 0 || eb == 0) begin
        m.special = 1'b1;
        m.res = {s, 31'd0};
        return m;
      end
      m.a = ma[31:0];
      m.b = mb[31:0];
      r = (ma * mb) >> 22;
      e = ea + eb - 127;
      if (r >= (64'd1 << 25)) begin e++; frac = 23'(r >> 2); end
      else frac = 23'(r >> 1);
    end else begin
      if (eb == 0) begin
        m.special = 1'b1;
        m.res = {s, 31'h7F80_0000};
        return m;
      end
      if (ea == 0) begin
        m.special = 1'b1;
        m.res = {s, 31'd0};
        return m;
      end
      m.a = ma[31:0];
      m.b = mb[31:0];
      r = (ma << 24) / mb;
      e = ea - eb + 127;
      if (r >= (64'd1 << 24)) frac = 23'(r >> 1);
      else begin e--; frac = 23'(r); end
    end
    if (e >= 255) m.res = {s, 8'hFF, 23'd0};
    else if (e <= 0) m.res = {s, 31'd0};
    else m.res = {s, 8'(e), frac};
    return m;
  endfunction

  exp_t        cur;
  bit          pending = 1'b0;
  int          t_start = 0;
  int          exp_lat = 0;
  int          en_cnt = 0;
  logic [31:0] last_fres = 32'd0;

  // Single compare process: every negedge the outputs are checked against the model state.
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outs", {fres, busy, done, alu_en, alu_ctrl, alu_a, alu_b}, 101'd0);
      last_fres = 32'd0;
    end else if (pending) begin
      if (alu_en) begin
        en_cnt++;
        chk("alu_issue", {alu_ctrl, alu_a, alu_b}, {cur.ctrl, cur.a, cur.b});
      end
      if (en_cnt > 0 && !done) chk("alu_hold", {alu_ctrl, alu_a, alu_b}, {cur.ctrl, cur.a, cur.b});
      if (done) begin
        chk("fres", fres, cur.res);
        chk("latency", cyc - t_start, exp_lat);
        chk("en_count", en_cnt, cur.special ? 0 : 1);
        chk("busy_at_done", busy, 1'b0);
        last_fres = fres;
        pending = 1'b0;
      end else if (cyc > t_start) begin
        chk("busy", busy, 1'b1);
      end
    end else begin
      chk("idle", {busy, done, alu_en, fres}, {3'b000, last_fres});
    end
  end

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input int lat, input bit extra_start);
    @(posedge clk); #2;
    op = o; fa = x; fb = y; alu_lat = lat;
    cur = model(o, x, y);
    exp_lat = cur.special ? 3 : 5 + lat;
    en_cnt = 0;
    t_start = cyc;
    pending = 1'b1;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    op = 2'($urandom); fa = $urandom; fb = $urandom;
    if (extra_start && !cur.special) begin
      @(posedge clk); #2;
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
    end
    for (int k = 0; k < 300 && pending; k++) @(posedge clk);
    if (pending) begin
      chk("done_timeout", 1'b0, 1'b1);
      pending = 1'b0;
    end
    @(posedge clk);
  endtask

  function automatic logic [31:0] rfloat();
    int k;
    logic [7:0] e;
    k = $urandom_range(0, 15);
    if (k == 0) e = 8'd0;
    else if (k == 1) e = 8'($urandom_range(230, 255));
    else if (k == 2) e = 8'($urandom_range(1, 30));
    else e = 8'($urandom_range(110, 145));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Hand-computed pins of the reference model itself.
    chk("pin_add",  model(2'd0, 32'h3FC0_0000, 32'h4010_0000).res, 32'h4070_0000);
    chk("pin_sub",  model(2'd1, 32'h3F80_0000, 32'h3F80_0000).res, 32'h0000_0000);
    chk("pin_mul",  model(2'd2, 32'h4040_0000, 32'h3F00_0000).res, 32'h3FC0_0000);
    chk("pin_mulof", model(2'd2, 32'h7F00_0000, 32'h4000_0000).res, 32'h7F80_0000);
    chk("pin_div",  model(2'd3, 32'h3F80_0000, 32'h4080_0000).res, 32'h3E80_0000);
    chk("pin_div0", model(2'd3, 32'h3F80_0000, 32'h0000_0000).res, 32'h7F80_0000);
    chk("pin_addctl", model(2'd0, 32'h3FC0_0000, 32'h4010_0000).ctrl, 2'd0);
    chk("pin_subctl", model(2'd1, 32'h3F80_0000, 32'h3F80_0000).ctrl, 2'd1);

    // Directed vectors.
    run(2'd0, 32'h3FC0_0000, 32'h4010_0000, 1, 1'b0);
    run(2'd1, 32'h3F80_0000, 32'h3F80_0000, 1, 1'b1);
    run(2'd2, 32'h4040_0000, 32'h3F00_0000, 1, 1'b0);
    run(2'd2, 32'h7F00_0000, 32'h4000_0000, 1, 1'b0);
    run(2'd3, 32'h3F80_0000, 32'h4080_0000, 6, 1'b0);
    run(2'd3, 32'h3F80_0000, 32'h0000_0000, 1, 1'b0);
    run(2'd3, 32'h0000_0000, 32'h0000_0000, 1, 1'b0);
    run(2'd0, 32'h0000_0000, 32'hC000_0000, 1, 1'b0);
    run(2'd1, 32'h0000_0000, 32'h4000_0000, 1, 1'b0);
    run(2'd0, 32'h4B80_0000, 32'h3F80_0000, 2, 1'b0);
    run(2'd1, 32'h3F80_0001, 32'h3F80_0000, 1, 1'b0);
    run(2'd2, 32'h0080_0000, 32'h0080_0000, 1, 1'b0);

    // Reset during WAITHI of a slow divide, then an add must still work.
    @(posedge clk); #2;
    op = 2'd3; fa = 32'h4040_0000; fb = 32'h3FC0_0000; alu_lat = 20;
    cur = model(2'd3, 32'h4040_0000, 32'h3FC0_0000);
    exp_lat = 25; en_cnt = 0; t_start = cyc; pending = 1'b1; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    pending = 1'b0;
    #1 chk("async_reset", {fres, busy, done, alu_en, alu_ctrl, alu_a, alu_b}, 101'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    run(2'd0, 32'h3FC0_0000, 32'h4010_0000, 1, 1'b0);

    // Randomized operations and ALU latencies.
    for (int n = 0; n < 80; n++) begin
      logic [31:0] x, y;
      x = rfloat();
      y = rfloat();
      if ($urandom_range(0, 3) == 0) y = {1'($urandom), x[30:23], 23'($urandom)};
      run(2'($urandom), x, y, $urandom_range(1, 4), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
